rf_wr_arbiter: RTL

Write-port arbiter for the 32x32 register file. It shares the single `we`/`waddr`/`wdata` port between two writeback sources. Requester 0 is the in-order pipeline writeback and has priority. Requester 1 is a multi-cycle unit (load return / mult-div) and is protected by a starvation limit. The grant is registered into a one-stage output that drives the register file directly. The block also flags pending-write address hits so the datapath can forward.

---
 rtl/rf_wr_arbiter.sv | 55 +++++
 1 files changed

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: two-source register-file write-port arbiter with starvation guard and pending-write hit flags
module rf_wr_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int STARVE_LIM = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_valid,
   output logic          r0_ready,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_data,
   input  logic          r1_valid,
   output logic          r1_ready,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_data,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   input  logic [AW-1:0] chk_addr1,
   input  logic [AW-1:0] chk_addr2,
   output logic          pend_hit1,
   output logic          pend_hit2,
   output logic [3:0]    starve_cnt
);
   localparam logic [3:0] LIM = 4'(STARVE_LIM);
   logic [3:0] cnt;
   logic force1, grant0, grant1;
   always_comb begin
      force1    = r1_valid && (cnt == LIM);
      r0_ready  = !force1;
      r1_ready  = !r0_valid || force1;
      grant0    = r0_valid && r0_ready;
      grant1    = r1_valid && r1_ready;
      pend_hit1 = rf_we && (chk_addr1 == rf_waddr);
      pend_hit2 = rf_we && (chk_addr2 == rf_waddr);
   end
   assign starve_cnt = cnt;
   // Register 0 writes are accepted but never enable the register file.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         cnt      <= '0;
      end else begin
         rf_we <= grant0 ? (r0_addr != '0) : (grant1 && (r1_addr != '0));
         if (grant0 || grant1) begin
            rf_waddr <= grant0 ? r0_addr : r1_addr;
            rf_wdata <= grant0 ? r0_data : r1_data;
         end
         cnt <= (!r1_valid || grant1) ? '0 : cnt + 4'(cnt != LIM);
      end
   end
endmodule
